// File: rtl/core_issue_pkg.sv
// Shared types and constants for the dual-issue front end.
//   iq_entry_t : one decoded instruction as held in the issue FIFO
//   pop2       : population count of a 2-bit vector (0..2)
package core_issue_pkg;

  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned SB_RID_W     = 4;
  localparam int unsigned SB_WID_W     = 5;
  // Payload width carried inside iq_entry_t; dual_issue_ctrl's PAYLOAD_W
  // must be left equal to this.
  localparam int unsigned IQ_PAYLOAD_W = 64;

  typedef struct packed {
    logic [1:0][REG_ADDR_W-1:0] rs;      // rs[0], rs[1]; 0 = unused / r0
    logic [REG_ADDR_W-1:0]      rd;      // 0 = no destination
    logic                       single;  // must issue alone in pipe 0
    logic [IQ_PAYLOAD_W-1:0]    payload;
  } iq_entry_t;

  function automatic logic [1:0] pop2(input logic [1:0] v);
    return {v[1] & v[0], v[1] ^ v[0]};
  endfunction

endpackage

// File: rtl/issue_fifo_2w2r.sv
// Dual-push / dual-pop circular instruction buffer.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   clear_i         : empties the buffer; same-cycle push/pop ignored
//   push_n_i        : entries to write this cycle (0..2), from push_entry_i[0..]
//   pop_n_i         : entries to retire from the head this cycle (0..2)
//   head0_o/head1_o : oldest and second-oldest entries (valid per count_o)
//   count_o         : registered occupancy
// The caller guarantees push/pop never overflow or underflow.
module issue_fifo_2w2r
  import core_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_i,
  input  logic [1:0]                 push_n_i,
  input  iq_entry_t [1:0]            push_entry_i,
  input  logic [1:0]                 pop_n_i,
  output iq_entry_t                  head0_o,
  output iq_entry_t                  head1_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  iq_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_n_i != 2'd0) mem_d[wr_ptr_q] = push_entry_i[0];
      if (push_n_i == 2'd2) mem_d[wr_ptr_q + PTR_W'(1)] = push_entry_i[1];
      // Pointers wrap naturally because DEPTH is a power of two.
      wr_ptr_d = wr_ptr_q + PTR_W'(push_n_i);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_n_i);
      count_d  = count_q + CNT_W'(push_n_i) - CNT_W'(pop_n_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head0_o = mem_q[rd_ptr_q];
  assign head1_o = mem_q[rd_ptr_q + PTR_W'(1)];
  assign count_o = count_q;

endmodule

// File: rtl/dual_issue_ctrl.sv
// Issue-side initiator for the dual-pipe scoreboard.
// Buffers decoded instructions, presents the two head entries to the
// scoreboard read ports, resolves intra-pair hazards (RAW, WAW, single)
// and hands issued instructions to the two execute pipes one cycle later.
// Ports:
//   dec_*  : decoder side; dec_valid_i[1] only with [0]; accepted when
//            dec_ready_o (room for two entries)
//   flush_i: backend redirect; empties the buffer, pulses sb_invalidate_o
//   sb_*   : scoreboard read addresses/flags/IDs, write addresses, issue
//            strobes (sb_is_o) and write ID for the issuing pair
//   ex_*   : registered issue to pipe 0 / pipe 1
// Handshake: an entry moves to pipe i in the cycle sb_is_o[i] is high;
// sb_is_o already includes ex_ready_i, so ex_valid_o is never held off.
module dual_issue_ctrl
  import core_issue_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PAYLOAD_W  = IQ_PAYLOAD_W
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [1:0]                            dec_valid_i,
  output logic                                  dec_ready_o,
  input  logic [1:0][1:0][REG_ADDR_W-1:0]       dec_rs_i,
  input  logic [1:0][REG_ADDR_W-1:0]            dec_rd_i,
  input  logic [1:0]                            dec_single_i,
  input  logic [1:0][PAYLOAD_W-1:0]             dec_payload_i,
  input  logic                                  flush_i,
  input  logic                                  sb_issue_ready_i,
  output logic [3:0][REG_ADDR_W-1:0]            sb_r_addr_o,
  input  logic [3:0]                            sb_r_valid_i,
  input  logic [3:0][SB_RID_W-1:0]              sb_r_id_i,
  output logic [1:0][REG_ADDR_W-1:0]            sb_w_addr_o,
  output logic [1:0]                            sb_is_o,
  input  logic [SB_WID_W-1:0]                   sb_w_id_i,
  output logic                                  sb_invalidate_o,
  input  logic [1:0]                            ex_ready_i,
  output logic [1:0]                            ex_valid_o,
  output logic [1:0][PAYLOAD_W-1:0]             ex_payload_o,
  output logic [1:0][1:0][SB_RID_W-1:0]         ex_r_id_o,
  output logic [SB_WID_W-1:0]                   ex_w_id_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  iq_entry_t [1:0]  push_entry;
  iq_entry_t        head0, head1;
  logic [CNT_W-1:0] count;
  logic [1:0]       push_n;
  logic [3:0]       src_rdy;
  logic             raw_hz, waw_hz, issue0, issue1;

  always_comb begin
    push_entry = '0;
    for (int i = 0; i < 2; i++) begin
      push_entry[i].rs      = dec_rs_i[i];
      push_entry[i].rd      = dec_rd_i[i];
      push_entry[i].single  = dec_single_i[i];
      push_entry[i].payload = dec_payload_i[i];
    end
  end

  // Ready is derived from the registered count only, so the decoder never
  // sees a combinational path from the issue decision.
  assign dec_ready_o = !rst && (count <= CNT_W'(FIFO_DEPTH - 2));
  assign push_n      = (dec_ready_o && !flush_i) ? pop2(dec_valid_i) : 2'd0;

  issue_fifo_2w2r #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (flush_i),
    .push_n_i     (push_n),
    .push_entry_i (push_entry),
    .pop_n_i      (pop2(sb_is_o)),
    .head0_o      (head0),
    .head1_o      (head1),
    .count_o      (count)
  );

  assign sb_r_addr_o     = {head1.rs[1], head1.rs[0], head0.rs[1], head0.rs[0]};
  assign sb_w_addr_o     = {head1.rd, head0.rd};
  assign sb_invalidate_o = flush_i && !rst;

  always_comb begin
    for (int j = 0; j < 2; j++) begin
      src_rdy[j]     = (head0.rs[j] == '0) || sb_r_valid_i[j];
      src_rdy[2 + j] = (head1.rs[j] == '0) || sb_r_valid_i[2 + j];
    end
  end

  // The scoreboard only tracks older in-flight writers; hazards between
  // the two heads themselves are resolved here.
  assign raw_hz = (head0.rd != '0) &&
                  ((head0.rd == head1.rs[0]) || (head0.rd == head1.rs[1]));
  assign waw_hz = (head0.rd != '0) && (head0.rd == head1.rd);

  assign issue0 = !rst && !flush_i && sb_issue_ready_i && ex_ready_i[0] &&
                  (count >= CNT_W'(1)) && (&src_rdy[1:0]);
  assign issue1 = issue0 && (count >= CNT_W'(2)) && ex_ready_i[1] &&
                  (&src_rdy[3:2]) && !head0.single && !head1.single &&
                  !raw_hz && !waw_hz;
  assign sb_is_o = {issue1, issue0};

  logic [1:0]                    ex_valid_q, ex_valid_d;
  logic [1:0][PAYLOAD_W-1:0]     ex_payload_q, ex_payload_d;
  logic [1:0][1:0][SB_RID_W-1:0] ex_r_id_q, ex_r_id_d;
  logic [SB_WID_W-1:0]           ex_w_id_q, ex_w_id_d;

  always_comb begin
    ex_valid_d   = sb_is_o;
    ex_payload_d = ex_payload_q;
    ex_r_id_d    = ex_r_id_q;
    ex_w_id_d    = ex_w_id_q;
    if (sb_is_o[0]) begin
      ex_payload_d[0] = head0.payload;
      ex_r_id_d[0]    = {sb_r_id_i[1], sb_r_id_i[0]};
      ex_w_id_d       = sb_w_id_i;
    end
    if (sb_is_o[1]) begin
      ex_payload_d[1] = head1.payload;
      ex_r_id_d[1]    = {sb_r_id_i[3], sb_r_id_i[2]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q   <= '0;
      ex_payload_q <= '0;
      ex_r_id_q    <= '0;
      ex_w_id_q    <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_payload_q <= ex_payload_d;
      ex_r_id_q    <= ex_r_id_d;
      ex_w_id_q    <= ex_w_id_d;
    end
  end

  assign ex_valid_o   = ex_valid_q;
  assign ex_payload_o = ex_payload_q;
  assign ex_r_id_o    = ex_r_id_q;
  assign ex_w_id_o    = ex_w_id_q;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
module tb_dual_issue_ctrl;

  logic                   clk;
  logic                   rst;
  logic [1:0]             dec_valid_i;
  logic                   dec_ready_o;
  logic [1:0][1:0][4:0]   dec_rs_i;
  logic [1:0][4:0]        dec_rd_i;
  logic [1:0]             dec_single_i;
  logic [1:0][63:0]       dec_payload_i;
  logic                   flush_i;
  logic                   sb_issue_ready_i;
  logic [3:0][4:0]        sb_r_addr_o;
  logic [3:0]             sb_r_valid_i;
  logic [3:0][3:0]        sb_r_id_i;
  logic [1:0][4:0]        sb_w_addr_o;
  logic [1:0]             sb_is_o;
  logic [4:0]             sb_w_id_i;
  logic                   sb_invalidate_o;
  logic [1:0]             ex_ready_i;
  logic [1:0]             ex_valid_o;
  logic [1:0][63:0]       ex_payload_o;
  logic [1:0][1:0][3:0]   ex_r_id_o;
  logic [4:0]             ex_w_id_o;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  dual_issue_ctrl #(.FIFO_DEPTH(4), .PAYLOAD_W(64)) dut (
    .clk              (clk),
    .rst              (rst),
    .dec_valid_i      (dec_valid_i),
    .dec_ready_o      (dec_ready_o),
    .dec_rs_i         (dec_rs_i),
    .dec_rd_i         (dec_rd_i),
    .dec_single_i     (dec_single_i),
    .dec_payload_i    (dec_payload_i),
    .flush_i          (flush_i),
    .sb_issue_ready_i (sb_issue_ready_i),
    .sb_r_addr_o      (sb_r_addr_o),
    .sb_r_valid_i     (sb_r_valid_i),
    .sb_r_id_i        (sb_r_id_i),
    .sb_w_addr_o      (sb_w_addr_o),
    .sb_is_o          (sb_is_o),
    .sb_w_id_i        (sb_w_id_i),
    .sb_invalidate_o  (sb_invalidate_o),
    .ex_ready_i       (ex_ready_i),
    .ex_valid_o       (ex_valid_o),
    .ex_payload_o     (ex_payload_o),
    .ex_r_id_o        (ex_r_id_o),
    .ex_w_id_o        (ex_w_id_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_slot(input int s, input logic [4:0] rs0, input logic [4:0] rs1,
                            input logic [4:0] rd, input logic single, input logic [63:0] pl);
    dec_rs_i[s][0]   = rs0;
    dec_rs_i[s][1]   = rs1;
    dec_rd_i[s]      = rd;
    dec_single_i[s]  = single;
    dec_payload_i[s] = pl;
  endtask

  // Scoreboard comparison
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int seen;
    int next_id;
    logic [63:0] e;

    rst = 1'b1; dec_valid_i = '0; dec_rs_i = '0; dec_rd_i = '0; dec_single_i = '0;
    dec_payload_i = '0; flush_i = 1'b1; sb_issue_ready_i = 1'b1; sb_r_valid_i = 4'hf;
    sb_r_id_i = '0; sb_w_id_i = '0; ex_ready_i = 2'b11;

    // ---- reset ----
    tick(); tick();
    check("rst_dec_ready", 64'(dec_ready_o), 0);
    check("rst_sb_is", 64'(sb_is_o), 0);
    check("rst_invalidate", 64'(sb_invalidate_o), 0);
    check("rst_ex_valid", 64'(ex_valid_o), 0);
    check("rst_ex_w_id", 64'(ex_w_id_o), 0);
    check("rst_ex_r_id", 64'(ex_r_id_o), 0);
    check("rst_ex_payload0", ex_payload_o[0], 0);
    check("rst_ex_payload1", ex_payload_o[1], 0);
    rst = 1'b0; flush_i = 1'b0;
    #1;
    check("post_rst_dec_ready", 64'(dec_ready_o), 1);

    // ---- independent pair ----
    drive_slot(0, 5'd1, 5'd2, 5'd3, 1'b0, 64'hA0);
    drive_slot(1, 5'd4, 5'd6, 5'd5, 1'b0, 64'hA1);
    dec_valid_i = 2'b11;
    tick();
    dec_valid_i = 2'b00; sb_w_id_i = 5'd17; sb_r_id_i = 16'h4321;
    #1;
    check("pair_sb_is", 64'(sb_is_o), 64'b11);
    check("pair_r_addr", 64'(sb_r_addr_o), 64'({5'd6, 5'd4, 5'd2, 5'd1}));
    check("pair_w_addr", 64'(sb_w_addr_o), 64'({5'd5, 5'd3}));
    check("pair_dec_ready_cnt2", 64'(dec_ready_o), 1);
    tick();
    sb_w_id_i = 5'd3; sb_r_id_i = 16'h9999;
    check("pair_ex_valid", 64'(ex_valid_o), 64'b11);
    check("pair_ex_w_id", 64'(ex_w_id_o), 17);
    check("pair_ex_r_id", 64'(ex_r_id_o), 64'h4321);
    check("pair_ex_pl0", ex_payload_o[0], 64'hA0);
    check("pair_ex_pl1", ex_payload_o[1], 64'hA1);
    #1;
    check("pair_empty_sb_is", 64'(sb_is_o), 0);
    tick();
    check("pair_ex_valid_drop", 64'(ex_valid_o), 0);
    check("pair_ex_w_id_hold", 64'(ex_w_id_o), 17);
    check("pair_ex_pl0_hold", ex_payload_o[0], 64'hA0);

    // ---- RAW pair ----
    drive_slot(0, 5'd1, 5'd0, 5'd7, 1'b0, 64'hB0);
    drive_slot(1, 5'd7, 5'd0, 5'd8, 1'b0, 64'hB1);
    dec_valid_i = 2'b11;
    tick();
    dec_valid_i = 2'b00;
    #1;
    check("raw_sb_is", 64'(sb_is_o), 64'b01);
    tick();
    check("raw_ex_valid0", 64'(ex_valid_o), 64'b01);
    check("raw_ex_pl0", ex_payload_o[0], 64'hB0);
    #1;
    check("raw_second_sb_is", 64'(sb_is_o), 64'b01);
    tick();
    check("raw_ex_pl1st", ex_payload_o[0], 64'hB1);
    tick();

    // ---- WAW pair ----
    drive_slot(0, 5'd1, 5'd2, 5'd9, 1'b0, 64'hC0);
    drive_slot(1, 5'd3, 5'd4, 5'd9, 1'b0, 64'hC1);
    dec_valid_i = 2'b11;
    tick();
    dec_valid_i = 2'b00;
    #1;
    check("waw_sb_is", 64'(sb_is_o), 64'b01);
    tick();
    #1;
    check("waw_second_sb_is", 64'(sb_is_o), 64'b01);
    tick();
    check("waw_ex_pl", ex_payload_o[0], 64'hC1);
    tick();

    // ---- head0 single ----
    drive_slot(0, 5'd0, 5'd0, 5'd10, 1'b1, 64'hD0);
    drive_slot(1, 5'd12, 5'd13, 5'd11, 1'b0, 64'hD1);
    dec_valid_i = 2'b11;
    tick();
    dec_valid_i = 2'b00;
    #1;
    check("single_sb_is", 64'(sb_is_o), 64'b01);
    tick();
    check("single_ex_pl", ex_payload_o[0], 64'hD0);
    #1;
    check("single_second_sb_is", 64'(sb_is_o), 64'b01);
    tick();
    check("single_ex_pl2", ex_payload_o[0], 64'hD1);
    tick();

    // ---- operand stall on head0.rs0 ----
    sb_r_valid_i = 4'b1110;
    drive_slot(0, 5'd4, 5'd0, 5'd20, 1'b0, 64'hE0);
    drive_slot(1, 5'd22, 5'd0, 5'd21, 1'b0, 64'hE1);
    dec_valid_i = 2'b11;
    tick();
    dec_valid_i = 2'b00;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("stall_sb_is_c%0d", c), 64'(sb_is_o), 0);
      tick();
    end
    sb_r_valid_i = 4'hf;
    #1;
    check("stall_release_sb_is", 64'(sb_is_o), 64'b11);
    tick();
    check("stall_ex_pl0", ex_payload_o[0], 64'hE0);
    check("stall_ex_pl1", ex_payload_o[1], 64'hE1);
    tick();

    // ---- fill, ready drop, wrap-around ordering ----
    ex_ready_i = 2'b00;
    for (int k = 0; k < 3; k++) begin
      drive_slot(0, 5'd0, 5'd0, 5'(k + 1), 1'b0, 64'(100 + k));
      dec_valid_i = 2'b01;
      exp_q.push_back(64'(100 + k));
      tick();
      dec_valid_i = 2'b00;
      if (k == 1) check("fill_ready_cnt2", 64'(dec_ready_o), 1);
    end
    check("fill_ready_cnt3", 64'(dec_ready_o), 0);
    drive_slot(0, 5'd0, 5'd0, 5'd1, 1'b0, 64'h999);
    dec_valid_i = 2'b01;
    tick();
    dec_valid_i = 2'b00;
    check("fill_ex_valid_blocked", 64'(ex_valid_o), 0);
    ex_ready_i = 2'b01;
    #1;
    check("fill_single_issue", 64'(sb_is_o), 64'b01);
    tick();
    check("fill_ready_reassert", 64'(dec_ready_o), 1);
    e = exp_q.pop_front();
    check("wrap_pl_0", ex_payload_o[0], e);
    seen = 1;
    next_id = 3;
    for (int cyc = 0; cyc < 30 && seen < 10; cyc++) begin
      if (next_id < 10 && dec_ready_o) begin
        drive_slot(0, 5'd0, 5'd0, 5'(next_id + 1), 1'b0, 64'(100 + next_id));
        dec_valid_i = 2'b01;
        exp_q.push_back(64'(100 + next_id));
        next_id++;
      end
      tick();
      dec_valid_i = 2'b00;
      if (ex_valid_o[0]) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hBAD;
        check($sformatf("wrap_pl_%0d", seen), ex_payload_o[0], e);
        seen++;
      end
    end
    check("wrap_count", 64'(seen), 10);
    tick();

    // ---- flush with 3 queued, issue_ready low afterwards ----
    ex_ready_i = 2'b00;
    drive_slot(0, 5'd0, 5'd0, 5'd1, 1'b0, 64'hF0);
    drive_slot(1, 5'd0, 5'd0, 5'd2, 1'b0, 64'hF1);
    dec_valid_i = 2'b11;
    tick();
    drive_slot(0, 5'd0, 5'd0, 5'd3, 1'b0, 64'hF2);
    dec_valid_i = 2'b01;
    tick();
    flush_i = 1'b1; sb_issue_ready_i = 1'b0; ex_ready_i = 2'b11;
    drive_slot(0, 5'd0, 5'd0, 5'd4, 1'b0, 64'hDEAD);
    dec_valid_i = 2'b01;
    #1;
    check("flush_invalidate", 64'(sb_invalidate_o), 1);
    check("flush_sb_is", 64'(sb_is_o), 0);
    tick();
    flush_i = 1'b0; dec_valid_i = 2'b00;
    check("flush_ex_valid", 64'(ex_valid_o), 0);
    #1;
    check("flush_invalidate_end", 64'(sb_invalidate_o), 0);
    check("flush_empty_ready", 64'(dec_ready_o), 1);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        drive_slot(0, 5'd1, 5'd2, 5'd3, 1'b0, 64'h60);
        drive_slot(1, 5'd4, 5'd5, 5'd6, 1'b0, 64'h61);
        dec_valid_i = 2'b11;
      end
      #1;
      check($sformatf("flush_hold_sb_is_c%0d", c), 64'(sb_is_o), 0);
      tick();
      dec_valid_i = 2'b00;
    end
    sb_issue_ready_i = 1'b1;
    #1;
    check("flush_resume_sb_is", 64'(sb_is_o), 64'b11);
    tick();
    check("flush_resume_pl0", ex_payload_o[0], 64'h60);
    check("flush_resume_pl1", ex_payload_o[1], 64'h61);
    tick();

    // ---- reset mid-operation ----
    ex_ready_i = 2'b00;
    drive_slot(0, 5'd0, 5'd0, 5'd1, 1'b0, 64'h70);
    drive_slot(1, 5'd0, 5'd0, 5'd2, 1'b0, 64'h71);
    dec_valid_i = 2'b11;
    tick();
    dec_valid_i = 2'b00;
    rst = 1'b1;
    #1;
    check("midrst_dec_ready", 64'(dec_ready_o), 0);
    tick();
    rst = 1'b0; ex_ready_i = 2'b11;
    #1;
    check("midrst_ready_after", 64'(dec_ready_o), 1);
    check("midrst_sb_is", 64'(sb_is_o), 0);
    check("midrst_ex_valid", 64'(ex_valid_o), 0);
    tick();
    check("midrst_ex_valid_next", 64'(ex_valid_o), 0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dual_issue_ctrl.md
Name: dual_issue_ctrl

Overview:
Issue-side initiator for the dual-pipe scoreboard. It buffers decoded instructions in a small FIFO and presents up to two head entries to the scoreboard read ports. It enforces all intra-pair conflicts that the scoreboard does not check, and drives the scoreboard `is_*` inputs. Issued instructions go to the two execution pipes together with their scoreboard IDs. It sits between the decoder and the two execute pipelines.

Parameters:
- FIFO_DEPTH, 4: instruction buffer entries; power of two, ≥4.
- PAYLOAD_W, 64: opaque decoded-instruction payload width, passed through unchanged.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- dec_valid_i  in  2  decoder instruction valid; [1] only when [0]
- dec_ready_o  out  1  FIFO can accept two entries
- dec_rs_i  in  2x2x5  source register addresses per instruction; 0 = unused/r0
- dec_rd_i  in  2x5  destination register address; 0 = none
- dec_single_i  in  2  instruction must issue alone in pipe 0
- dec_payload_i  in  2xPAYLOAD_W  payload
- flush_i  in  1  backend redirect
- sb_issue_ready_i  in  1  scoreboard issue_ready
- sb_r_addr_o  out  4x5  {head1.rs1, head1.rs0, head0.rs1, head0.rs0}
- sb_r_valid_i  in  4  operand-ready flags, index-matched to sb_r_addr_o
- sb_r_id_i  in  4x4  forwarding IDs, index-matched
- sb_w_addr_o  out  2x5  head0.rd, head1.rd
- sb_is_o  out  2  issue strobes to scoreboard
- sb_w_id_i  in  5  write ID for this cycle's issue pair
- sb_invalidate_o  out  1  scoreboard invalidate
- ex_ready_i  in  2  execute pipe accepts an instruction
- ex_valid_o  out  2  issued-instruction valid, registered
- ex_payload_o  out  2xPAYLOAD_W  issued payload, registered
- ex_r_id_o  out  2x2x4  source IDs, registered
- ex_w_id_o  out  5  write ID, registered

Behaviour:
- Reset: FIFO empty, `ex_valid_o`=0, `ex_w_id_o`=0, `ex_r_id_o`=0, `ex_payload_o`=0, `sb_is_o`=0, `sb_invalidate_o`=0, `dec_ready_o`=0 during reset and 1 in the first cycle after it.
- FIFO:
  - Circular buffer with wrapping read/write pointers and an occupancy count of log2(FIFO_DEPTH)+1 bits.
  - `dec_ready_o` = (count ≤ FIFO_DEPTH−2), computed from registered count only.
  - Enqueue 0/1/2 entries when `dec_ready_o`; dequeue 0/1/2 per cycle. Simultaneous enqueue and dequeue is allowed.
- Operand readiness: a source is ready when rs == 0 or the matching `sb_r_valid_i` bit is set. Entries beyond count are treated as invalid; their sb address outputs are don't-care but sb_is stays 0.
- Slot 0 issues when all of the following hold:
  - count ≥ 1
  - `sb_issue_ready_i`
  - `!flush_i`
  - `ex_ready_i[0]`
  - both head0 sources ready
- Slot 1 issues only when slot 0 issues, and also:
  - count ≥ 2
  - `ex_ready_i[1]`
  - head1 sources ready
  - neither head0 nor head1 is single
  - no RAW: head0.rd ≠ 0 and head0.rd equals either head1.rs
  - no WAW: head0.rd ≠ 0 and head0.rd == head1.rd
- `sb_is_o` is combinational and equals the issue decisions; dequeue count equals popcount(`sb_is_o`).
- Execute outputs:
  - Next cycle: `ex_valid_o` ← `sb_is_o`; payload, r_id and `ex_w_id_o` ← `sb_w_id_i` latched from the issue cycle. One-cycle latency.
  - When ex_valid bits are 0, the other ex fields hold their previous value.
- Flush:
  - In the `flush_i` cycle, issue is suppressed, FIFO count and pointers reset to empty, and any same-cycle enqueue is dropped.
  - `sb_invalidate_o` = `flush_i` (combinational pulse).
  - `ex_valid_o` ← 0 next cycle.
  - Issue resumes only once `sb_issue_ready_i` returns high.
- Reset mid-operation: identical to reset; in-flight entries are discarded.

Decomposition:
- Shared package (e.g. `core_issue_pkg`) holds:
  - `iq_entry_t` struct {rs[2], rd, single, payload}
  - REG_ADDR_W=5, SB_RID_W=4, SB_WID_W=5
- One sub-module `issue_fifo_2w2r`: dual-push/dual-pop circular FIFO exposing head0/head1 and count. Conflict and readiness logic stays in the top module.

Test Plan:
- Independent pair, for example add r3,r1,r2 and add r5,r4,r6 with all sources ready → `sb_is_o`=2'b11 in one cycle; `ex_valid_o`=11 next cycle with `ex_w_id_o` equal to the latched `sb_w_id_i`.
- RAW pair: head0 rd=r7, head1 rs0=r7 → `sb_is_o`=01; the next cycle head1 is head0 and issues as 01 (given ready).
- WAW pair on rd=r9, plus head0 single=1 with an independent head1 → both cases give `sb_is_o`=01.
- `sb_r_valid_i`[0]=0 on head0 rs0=r4 for 3 cycles → `sb_is_o`=00 for those 3 cycles; head1 never bypasses head0; issue happens in cycle 4 when valid goes high.
- Fill FIFO (depth 4) with `ex_ready_i`=00 → `dec_ready_o` drops when count=3; it reasserts after a single issue; pointer wrap-around is verified over 10 instructions in order.
- `flush_i` with 3 entries queued and `sb_issue_ready_i` low for 5 cycles afterwards → `sb_invalidate_o`=1 for 1 cycle, FIFO empty, no `sb_is_o` until new instructions arrive and ready returns.
